// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the F/D/E/M/W pipeline.
// Turns hazard events into en/flush controls for each inter-stage register
// and for the PC. A redirect that lands while a fetch is still outstanding
// is parked in r_pend_pc and applied once that wrong-path fetch returns.
// Also counts the cycles in which the PC is held.
//
// state  | meaning
// S_RUN  | normal issue; hazards resolved by priority
// S_WAIT | redirect pending; wrong-path fetch still outstanding
module pipe_hazard_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_stall,
    input  logic             d_stall,
    input  logic             e_busy,
    input  logic             load_use,
    input  logic             br_valid,
    input  logic [XLEN-1:0]  br_target,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_target,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             f2d_en,
    output logic             f2d_flush,
    output logic             d2e_en,
    output logic             d2e_flush,
    output logic             e2m_en,
    output logic             e2m_flush,
    output logic             m2w_en,
    output logic             m2w_flush,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t            r_state;
    state_t            w_nxt_state;
    logic [XLEN-1:0]   r_pend_pc;
    logic [XLEN-1:0]   w_nxt_pend;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_trap_take;

    // A trap in M cannot be taken while M itself is frozen on dmem.
    assign w_trap_take = trap_valid & ~d_stall;

    // Pipeline controls and next state from current state and hazards.
    always_comb begin
        pc_en       = 1'b1;
        pc_redirect = 1'b0;
        redirect_pc = '0;
        f2d_en      = 1'b1;
        f2d_flush   = 1'b0;
        d2e_en      = 1'b1;
        d2e_flush   = 1'b0;
        e2m_en      = 1'b1;
        e2m_flush   = 1'b0;
        m2w_en      = 1'b1;
        m2w_flush   = 1'b0;
        w_nxt_state = r_state;
        w_nxt_pend  = r_pend_pc;
        if (!reset) begin
            pc_en     = 1'b0;
            f2d_en    = 1'b0;
            f2d_flush = 1'b1;
            d2e_en    = 1'b0;
            d2e_flush = 1'b1;
            e2m_en    = 1'b0;
            e2m_flush = 1'b1;
            m2w_en    = 1'b0;
            m2w_flush = 1'b1;
        end else if (r_state == S_RUN) begin
            if (w_trap_take) begin
                f2d_flush   = 1'b1;
                d2e_flush   = 1'b1;
                e2m_flush   = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = trap_target;
                if (i_stall) begin
                    pc_en       = 1'b0;
                    w_nxt_pend  = trap_target;
                    w_nxt_state = S_WAIT;
                end
            end else if (d_stall) begin
                pc_en     = 1'b0;
                f2d_en    = 1'b0;
                d2e_en    = 1'b0;
                e2m_en    = 1'b0;
                m2w_flush = 1'b1;
            end else if (e_busy) begin
                pc_en     = 1'b0;
                f2d_en    = 1'b0;
                d2e_en    = 1'b0;
                e2m_flush = 1'b1;
            end else if (br_valid) begin
                f2d_flush   = 1'b1;
                d2e_flush   = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = br_target;
                if (i_stall) begin
                    pc_en       = 1'b0;
                    w_nxt_pend  = br_target;
                    w_nxt_state = S_WAIT;
                end
            end else if (load_use) begin
                pc_en     = 1'b0;
                f2d_en    = 1'b0;
                d2e_flush = 1'b1;
            end else if (i_stall) begin
                pc_en     = 1'b0;
                f2d_flush = 1'b1;
            end
        end else begin
            // Upstream is already flushed, so branches and load-use are moot;
            // F/D keeps bubbling until the wrong-path word has been dropped.
            pc_en     = 1'b0;
            f2d_flush = 1'b1;
            if (w_trap_take) begin
                d2e_flush  = 1'b1;
                e2m_flush  = 1'b1;
                w_nxt_pend = trap_target;
            end else if (d_stall) begin
                d2e_en    = 1'b0;
                e2m_en    = 1'b0;
                m2w_flush = 1'b1;
            end else if (e_busy) begin
                d2e_en    = 1'b0;
                e2m_flush = 1'b1;
            end
            if (!i_stall) begin
                pc_en       = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = w_trap_take ? trap_target : r_pend_pc;
                w_nxt_state = S_RUN;
            end
        end
    end

    // State and pending redirect target; reset drops any pending redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_RUN;
            r_pend_pc <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_pend_pc <= w_nxt_pend;
        end
    end

    // Saturating count of cycles with the PC held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (!pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: fixed vector table, directed multi-cycle
// sequences and random traffic, all compared against a stage-action model.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic        is, d, e, lu, br, tr;
        logic [63:0] bt, tt;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic [9:0]  ctl;
        logic [63:0] rpc;
    } vec_t;

    typedef enum int {A_ADV, A_HOLD, A_BUB} act_e;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_stall, d_stall, e_busy, load_use, br_valid, trap_valid;
    logic [63:0] br_target, trap_target;
    logic        pc_en, pc_redirect;
    logic [63:0] redirect_pc;
    logic        f2d_en, f2d_flush, d2e_en, d2e_flush;
    logic        e2m_en, e2m_flush, m2w_en, m2w_flush;
    logic [31:0] stall_cnt;
    logic        s_pc_en, s_pc_redirect;
    logic [63:0] s_redirect_pc;
    logic        s_f2d_en, s_f2d_flush, s_d2e_en, s_d2e_flush;
    logic        s_e2m_en, s_e2m_flush, s_m2w_en, s_m2w_flush;
    logic [3:0]  s_stall_cnt;

    int n_vec = 0;
    int n_bad = 0;

    bit          m_wait;
    logic [63:0] m_pend;
    logic [31:0] m_cnt;
    logic [3:0]  m_cnt4;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.XLEN(64), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .i_stall(i_stall), .d_stall(d_stall),
        .e_busy(e_busy), .load_use(load_use), .br_valid(br_valid),
        .br_target(br_target), .trap_valid(trap_valid), .trap_target(trap_target),
        .pc_en(pc_en), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
        .f2d_en(f2d_en), .f2d_flush(f2d_flush), .d2e_en(d2e_en), .d2e_flush(d2e_flush),
        .e2m_en(e2m_en), .e2m_flush(e2m_flush), .m2w_en(m2w_en), .m2w_flush(m2w_flush),
        .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.XLEN(64), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .i_stall(i_stall), .d_stall(d_stall),
        .e_busy(e_busy), .load_use(load_use), .br_valid(br_valid),
        .br_target(br_target), .trap_valid(trap_valid), .trap_target(trap_target),
        .pc_en(s_pc_en), .pc_redirect(s_pc_redirect), .redirect_pc(s_redirect_pc),
        .f2d_en(s_f2d_en), .f2d_flush(s_f2d_flush), .d2e_en(s_d2e_en), .d2e_flush(s_d2e_flush),
        .e2m_en(s_e2m_en), .e2m_flush(s_e2m_flush), .m2w_en(s_m2w_en), .m2w_flush(s_m2w_flush),
        .stall_cnt(s_stall_cnt)
    );

    function automatic stim_t mk(bit is, bit d, bit e, bit lu, bit br, bit tr,
                                 logic [63:0] bt, logic [63:0] tt);
        stim_t s;
        s.is = is; s.d = d; s.e = e; s.lu = lu; s.br = br; s.tr = tr;
        s.bt = bt; s.tt = tt;
        return s;
    endfunction

    function automatic logic [9:0] dut_ctl();
        return {pc_en, pc_redirect, f2d_en, f2d_flush, d2e_en, d2e_flush,
                e2m_en, e2m_flush, m2w_en, m2w_flush};
    endfunction

    // Reference: each hazard either freezes everything younger than the
    // stage it sits in (and bubbles that stage's input register) or kills
    // everything younger (bubbling all registers upstream of it).
    task automatic ref_model(input stim_t s, input bit waiting, input logic [63:0] pend,
                             output logic [9:0] ctl, output logic [63:0] rpc,
                             output bit nwait, output logic [63:0] npend);
        act_e a[4];
        int fz = -1;
        int kill = 0;
        logic [63:0] tgt = '0;
        bit pe;
        bit rd = 1'b0;
        rpc = '0;
        nwait = waiting;
        npend = pend;
        for (int i = 0; i < 4; i++) a[i] = A_ADV;
        if (s.tr && !s.d)               begin kill = 3; tgt = s.tt; end
        else if (s.d)                   fz = 3;
        else if (s.e)                   fz = 2;
        else if (!waiting && s.br)      begin kill = 2; tgt = s.bt; end
        else if (!waiting && s.lu)      fz = 1;
        else if (!waiting && s.is)      fz = 0;
        for (int i = 0; i < kill; i++) a[i] = A_BUB;
        if (fz >= 0) begin
            for (int i = 0; i < fz; i++) a[i] = A_HOLD;
            a[fz] = A_BUB;
        end
        if (!waiting) begin
            if (kill > 0) begin
                rd = 1'b1;
                rpc = tgt;
                pe = !s.is;
                if (s.is) begin nwait = 1'b1; npend = tgt; end
            end else begin
                pe = (fz < 0);
            end
        end else begin
            a[0] = A_BUB;
            pe = 1'b0;
            if (kill > 0) npend = tgt;
            if (!s.is) begin
                pe = 1'b1;
                rd = 1'b1;
                rpc = (kill > 0) ? tgt : pend;
                nwait = 1'b0;
            end
        end
        ctl[9] = pe;
        ctl[8] = rd;
        for (int i = 0; i < 4; i++) begin
            ctl[7 - 2*i] = (a[i] != A_HOLD);
            ctl[6 - 2*i] = (a[i] == A_BUB);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive, check against the model mid-cycle, advance model.
    task automatic step(input stim_t s, input bit rst_v);
        logic [9:0]  e_ctl;
        logic [63:0] e_rpc;
        bit          nw;
        logic [63:0] np;
        @(posedge clk);
        #1;
        i_stall = s.is; d_stall = s.d; e_busy = s.e; load_use = s.lu;
        br_valid = s.br; trap_valid = s.tr; br_target = s.bt; trap_target = s.tt;
        reset = rst_v;
        if (!rst_v) begin
            m_wait = 1'b0; m_pend = '0; m_cnt = '0; m_cnt4 = '0;
            e_ctl = 10'b00_01_01_01_01;
            e_rpc = '0;
            nw = 1'b0;
            np = '0;
        end else begin
            ref_model(s, m_wait, m_pend, e_ctl, e_rpc, nw, np);
        end
        @(negedge clk);
        chk("ctl", 64'(dut_ctl()), 64'(e_ctl));
        chk("redirect_pc", redirect_pc, e_rpc);
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        chk("stall_cnt4", 64'(s_stall_cnt), 64'(m_cnt4));
        if (rst_v) begin
            m_wait = nw;
            m_pend = np;
            if (!e_ctl[9]) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
            end
        end
    endtask

    vec_t tbl[9];
    stim_t idle;
    int timeout = 0;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
        //            is d e lu br tr  bt                tt
        tbl[0] = '{mk(0,0,0,0,0,0, 64'h0,           64'h0),        10'b10_10_10_10_10, 64'h0};
        tbl[1] = '{mk(0,0,0,1,0,0, 64'h0,           64'h0),        10'b00_00_11_10_10, 64'h0};
        tbl[2] = '{mk(1,0,0,0,0,0, 64'h0,           64'h0),        10'b00_11_10_10_10, 64'h0};
        tbl[3] = '{mk(0,0,1,1,1,0, 64'h55,          64'h0),        10'b00_00_00_11_10, 64'h0};
        tbl[4] = '{mk(0,1,0,0,1,1, 64'h66,          64'h77),       10'b00_00_00_00_11, 64'h0};
        tbl[5] = '{mk(0,0,0,0,1,0, 64'h1234,        64'h0),        10'b11_11_11_10_10, 64'h1234};
        tbl[6] = '{mk(0,0,1,0,1,1, 64'h1234,        64'hABC0),     10'b11_11_11_11_10, 64'hABC0};
        tbl[7] = '{mk(1,0,0,1,1,0, 64'hDEAD_0000,   64'h0),        10'b01_11_11_10_10, 64'hDEAD_0000};
        tbl[8] = '{mk(1,0,0,1,0,0, 64'h0,           64'h0),        10'b00_00_11_10_10, 64'h0};

        reset = 1'b0;
        i_stall = 0; d_stall = 0; e_busy = 0; load_use = 0;
        br_valid = 0; trap_valid = 0; br_target = '0; trap_target = '0;
        m_wait = 0; m_pend = '0; m_cnt = '0; m_cnt4 = '0;
        step(idle, 1'b0);
        step(idle, 1'b0);

        // Reset release, no hazards.
        for (int i = 0; i < 5; i++) step(idle, 1'b1);
        chk("idle_ctl", 64'(dut_ctl()), 64'(10'b10_10_10_10_10));
        chk("idle_cnt", 64'(stall_cnt), 64'd0);

        // Single-cycle table, each followed by a recovery cycle.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].s, 1'b1);
            chk($sformatf("tbl%0d_ctl", i), 64'(dut_ctl()), 64'(tbl[i].ctl));
            chk($sformatf("tbl%0d_rpc", i), redirect_pc, tbl[i].rpc);
            step(idle, 1'b1);
        end

        // Load-use bumps the counter by one.
        step(idle, 1'b0);
        step(idle, 1'b1);
        step(mk(0,0,0,1,0,0, 64'h0, 64'h0), 1'b1);
        step(idle, 1'b1);
        chk("lu_next_ctl", 64'(dut_ctl()), 64'(10'b10_10_10_10_10));
        chk("lu_cnt", 64'(stall_cnt), 64'd1);

        // Branch during an outstanding fetch.
        step(mk(1,0,0,0,1,0, 64'h8000_1000, 64'h0), 1'b1);
        step(mk(1,0,0,0,0,0, 64'h0, 64'h0), 1'b1);
        step(mk(1,0,0,0,0,0, 64'h0, 64'h0), 1'b1);
        chk("br_wait_pc_en", 64'(pc_en), 64'd0);
        step(idle, 1'b1);
        chk("br_redir", 64'(pc_redirect), 64'd1);
        chk("br_redir_pc", redirect_pc, 64'h8000_1000);
        chk("br_redir_f2d_flush", 64'(f2d_flush), 64'd1);
        step(idle, 1'b1);
        chk("br_after", 64'(dut_ctl()), 64'(10'b10_10_10_10_10));

        // Trap overwrites the pending branch redirect.
        step(mk(1,0,0,0,1,0, 64'h8000_1000, 64'h0), 1'b1);
        step(mk(1,0,0,0,0,1, 64'h0, 64'h8000_0100), 1'b1);
        chk("trap_flush", 64'({f2d_flush, d2e_flush, e2m_flush}), 64'd7);
        step(mk(1,0,0,0,0,0, 64'h0, 64'h0), 1'b1);
        step(idle, 1'b1);
        chk("trap_redir_pc", redirect_pc, 64'h8000_0100);
        step(idle, 1'b1);

        // Dmem stall holds the branch in E until it completes.
        step(mk(0,1,0,1,1,0, 64'h4000_0040, 64'h0), 1'b1);
        step(mk(0,1,0,1,1,0, 64'h4000_0040, 64'h0), 1'b1);
        chk("dst_ctl", 64'(dut_ctl()), 64'(10'b00_00_00_00_11));
        step(mk(0,0,0,1,1,0, 64'h4000_0040, 64'h0), 1'b1);
        chk("dst_br_redir", 64'(pc_redirect), 64'd1);
        chk("dst_br_pc", redirect_pc, 64'h4000_0040);
        step(idle, 1'b1);

        // Narrow counter saturation, then reset in the middle of a wait.
        step(idle, 1'b0);
        for (int i = 0; i < 20; i++) step(mk(1,0,0,0,0,0, 64'h0, 64'h0), 1'b1);
        chk("cnt4_sat", 64'(s_stall_cnt), 64'd15);
        step(mk(1,0,0,0,1,0, 64'h9000, 64'h0), 1'b1);
        step(mk(1,0,0,0,0,0, 64'h0, 64'h0), 1'b1);
        step(idle, 1'b0);
        step(idle, 1'b1);
        chk("rst_wait_redir", 64'(pc_redirect), 64'd0);
        chk("rst_wait_pc_en", 64'(pc_en), 64'd1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            stim_t s;
            s.is = ($urandom_range(0, 99) < 35);
            s.d  = ($urandom_range(0, 99) < 10);
            s.e  = ($urandom_range(0, 99) < 10);
            s.lu = ($urandom_range(0, 99) < 15);
            s.br = ($urandom_range(0, 99) < 15);
            s.tr = ($urandom_range(0, 99) < 8);
            s.bt = {$urandom, $urandom};
            s.tt = {$urandom, $urandom};
            step(s, ($urandom_range(0, 99) >= 2));
            timeout++;
        end

        if (timeout != 600) begin
            n_bad++;
            $display("FAIL random_loop: got %0d expected 600", timeout);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage in-order pipeline (F/D/E/M/W).
- Takes memory busy, multicycle-execute busy, load-use, branch and trap events. Drives the en/flush pair of each inter-stage pipeline register and the PC update.
- Holds a pending redirect across an outstanding instruction fetch so the wrong-path fetch is discarded.
- Keeps a stall-cycle performance counter.

Parameters:
- XLEN, 64, PC/target width.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- i_stall  in  1  imem fetch outstanding; F result not yet valid.
- d_stall  in  1  dmem access in M not complete.
- e_busy  in  1  multicycle mul/div in E not done.
- load_use  in  1  D needs the rd of a load currently in E.
- br_valid  in  1  E resolved a taken/mispredicted branch.
- br_target  in  XLEN  branch target.
- trap_valid  in  1  M raises exception/interrupt.
- trap_target  in  XLEN  trap vector.
- pc_en  out  1  PC register update enable.
- pc_redirect  out  1  PC loads redirect_pc instead of sequential PC.
- redirect_pc  out  XLEN  redirect target.
- f2d_en, f2d_flush  out  1,1  F/D register controls.
- d2e_en, d2e_flush  out  1,1  D/E register controls.
- e2m_en, e2m_flush  out  1,1  E/M register controls.
- m2w_en, m2w_flush  out  1,1  M/W register controls.
- stall_cnt  out  CNT_W  cycles with pc_en=0 since reset.

Behaviour:
- All outputs combinational from state and inputs, except stall_cnt (registered).
- While reset=0:
  - all *_en=0, all *_flush=1, pc_en=0, pc_redirect=0, redirect_pc=0.
  - state=RUN, pend_pc=0, stall_cnt=0.
  - Reset mid-WAIT_FETCH discards the pending redirect.
- Default in RUN: all en=1, all flush=0, pc_en=1.
- Priority, highest first. A frozen stage has en=0; a bubble sets flush=1 on the register feeding the next stage.
  1. trap_valid (and d_stall=0):
     - f2d/d2e/e2m flush=1; m2w_en=1.
     - pc_redirect=1, redirect_pc=trap_target.
     - If i_stall=1: pc_en=0, latch pend_pc=trap_target, go WAIT_FETCH.
  2. d_stall:
     - pc_en=0; f2d/d2e/e2m en=0; m2w_flush=1.
     - br_valid and trap_valid are held by their frozen stages and are not acted on.
  3. e_busy: pc_en=0; f2d/d2e en=0; e2m_flush=1.
  4. br_valid:
     - f2d/d2e flush=1; pc_redirect=1, redirect_pc=br_target.
     - If i_stall=1: pc_en=0, latch pend_pc=br_target, go WAIT_FETCH.
  5. load_use: pc_en=0; f2d_en=0; d2e_flush=1.
  6. i_stall: pc_en=0; f2d_flush=1.
- Flush overrides en on the same register; flush with en=0 is never emitted except during reset.
- WAIT_FETCH (redirect pending; wrong-path fetch outstanding):
  - pc_en=0, pc_redirect=0, f2d_flush=1.
  - br_valid ignored: the upstream was already flushed.
  - trap_valid overwrites pend_pc, with the trap side effects of rule 1.
  - d_stall and e_busy apply to the D..W registers as in RUN.
  - When i_stall=0: pc_en=1, pc_redirect=1, redirect_pc=pend_pc, f2d_flush=1 (discard the returned wrong-path word), return to RUN.
  - If i_stall=0 and trap_valid occur together, trap_target wins.
- stall_cnt increments on every cycle with reset=1 and pc_en=0.
  - Saturates at all-ones; no wrap.

Test Plan:
- Reset released, no hazards for 5 cycles -> all en=1, flush=0, pc_en=1, stall_cnt=0.
- load_use=1 for 1 cycle -> that cycle pc_en=0, f2d_en=0, d2e_flush=1; next cycle all en=1; stall_cnt=1.
- br_valid=1, br_target=0x80001000, i_stall=1 for 3 cycles then 0:
  - Cycles 0-2: pc_en=0, f2d_flush=1.
  - Cycle 3: pc_redirect=1, redirect_pc=0x80001000, f2d_flush=1.
  - Cycle 4: RUN defaults.
- Same as above but trap_valid=1, trap_target=0x80000100 in cycle 1 -> cycle 3 redirect_pc=0x80000100; cycle 1 shows f2d/d2e/e2m flush.
- d_stall=1 with br_valid=1 and load_use=1 for 2 cycles:
  - pc_en=0, f2d/d2e/e2m en=0, m2w_flush=1, pc_redirect=0.
  - After d_stall drops, the branch is redirected.
- Force stall_cnt near max (CNT_W=4 variant), hold i_stall=1 20 cycles -> stall_cnt=15 and stays. Assert reset=0 mid-WAIT_FETCH -> on release state RUN, no redirect emitted.
